// File: rtl/fb_write_sched.sv
// Framebuffer write scheduler: PPU pixel FIFO, optional clear engine, OSD port.
// Clear engine compiled only when FB_CLEAR_EN is defined.
module fb_write_sched #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [5:0]  CLEAR_COLOR = 6'h0F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ppu_valid,
  input  logic [8:0]  ppu_x,
  input  logic [8:0]  ppu_y,
  input  logic [5:0]  ppu_pixel,
  input  logic        osd_valid,
  input  logic [15:0] osd_addr,
  input  logic [5:0]  osd_pixel,
  output logic        osd_ready,
  input  logic        clear_req,
  output logic        clear_busy,
  output logic        fb_wren,
  output logic [15:0] fb_addr,
  output logic [5:0]  fb_data,
  output logic        ppu_overflow
);

  localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [15:0] LAST_ADDR = 16'd61439;

  typedef struct packed {
    logic [15:0] addr;
    logic [5:0]  data;
  } entry_t;

  entry_t           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             fb_wren_q, fb_wren_d;
  logic [15:0]      fb_addr_q, fb_addr_d;
  logic [5:0]       fb_data_q, fb_data_d;

  logic   ppu_qual, fifo_empty, fifo_full, fifo_pop, fifo_push;
  logic   clear_busy_int, clear_grant;
  logic   osd_ready_int;
  logic   grant_hold;
  entry_t head, push_entry;

  // Constant-low hook that freezes FIFO drain when driven high.
  assign grant_hold = 1'b0;

  always_comb begin
    ppu_qual   = ppu_valid && (ppu_x < 9'd256) && (ppu_y < 9'd240);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == DEPTH_CNT);
    fifo_pop   = !fifo_empty && !grant_hold;
    fifo_push  = ppu_qual && (!fifo_full || fifo_pop);
    head       = mem_q[rd_ptr_q];
    push_entry = '{addr: {ppu_y[7:0], ppu_x[7:0]}, data: ppu_pixel};
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (fifo_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (fifo_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({fifo_push, fifo_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
    if (ppu_qual && fifo_full && !fifo_pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (fifo_push) mem_q[wr_ptr_q] <= push_entry;
  end

`ifdef FB_CLEAR_EN
  typedef enum logic [1:0] {IDLE, ARMED, CLEAR} clr_state_e;

  clr_state_e  state_q, state_d;
  logic [15:0] clr_cnt_q, clr_cnt_d;

  assign clear_busy_int = (state_q != IDLE);
  assign clear_grant    = (state_q == CLEAR) && fifo_empty;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      IDLE:  if (clear_req) state_d = ARMED;
      ARMED: if (ppu_y >= 9'd240) state_d = CLEAR;
      CLEAR: begin
        if (clear_grant) begin
          if (clr_cnt_q == LAST_ADDR) begin
            state_d   = IDLE;
            clr_cnt_d = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end
`else
  logic        unused_clear;
  logic [15:0] clr_cnt_q;

  assign unused_clear   = ^{clear_req, CLEAR_COLOR};
  assign clear_busy_int = 1'b0;
  assign clear_grant    = 1'b0;
  assign clr_cnt_q      = '0;
`endif

  assign osd_ready_int = fifo_empty && !clear_busy_int;

  // Fixed priority: FIFO, then clear engine, then OSD.
  always_comb begin
    fb_wren_d = 1'b0;
    fb_addr_d = '0;
    fb_data_d = '0;
    if (fifo_pop) begin
      fb_wren_d = 1'b1;
      fb_addr_d = head.addr;
      fb_data_d = head.data;
    end else if (clear_grant) begin
      fb_wren_d = 1'b1;
      fb_addr_d = clr_cnt_q;
      fb_data_d = CLEAR_COLOR;
    end else if (osd_valid && osd_ready_int) begin
      fb_wren_d = 1'b1;
      fb_addr_d = osd_addr;
      fb_data_d = osd_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      fb_wren_q  <= 1'b0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      fb_wren_q  <= fb_wren_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
    end
  end

  assign osd_ready    = osd_ready_int;
  assign clear_busy   = clear_busy_int;
  assign fb_wren      = fb_wren_q;
  assign fb_addr      = fb_addr_q;
  assign fb_data      = fb_data_q;
  assign ppu_overflow = overflow_q;

endmodule

// File: tb/tb_fb_write_sched.sv
// Self-checking bench for fb_write_sched against a queue-based reference model.
// Clear-engine scenarios run only when FB_CLEAR_EN is defined.
module tb_fb_write_sched;

  localparam int          DEPTH = 4;
  localparam logic [5:0]  CC    = 6'h0F;

  logic        clk, rst_n;
  logic        ppu_valid;
  logic [8:0]  ppu_x, ppu_y;
  logic [5:0]  ppu_pixel;
  logic        osd_valid;
  logic [15:0] osd_addr;
  logic [5:0]  osd_pixel;
  logic        osd_ready;
  logic        clear_req;
  logic        clear_busy;
  logic        fb_wren;
  logic [15:0] fb_addr;
  logic [5:0]  fb_data;
  logic        ppu_overflow;

  fb_write_sched #(.FIFO_DEPTH(DEPTH), .CLEAR_COLOR(CC)) dut (
    .clk(clk), .rst_n(rst_n),
    .ppu_valid(ppu_valid), .ppu_x(ppu_x), .ppu_y(ppu_y), .ppu_pixel(ppu_pixel),
    .osd_valid(osd_valid), .osd_addr(osd_addr), .osd_pixel(osd_pixel),
    .osd_ready(osd_ready),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .fb_wren(fb_wren), .fb_addr(fb_addr), .fb_data(fb_data),
    .ppu_overflow(ppu_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: pending pixel writes, clear progress, sticky drop flag.
  logic [21:0] q[$];
  bit          hold;
  bit          m_armed, m_active, m_ovf;
  int          m_caddr;
  int          n_writes, clr_writes, last_clr_addr;

  function automatic bit m_busy();
    return m_armed || m_active;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit          ew, ready, busy0;
    logic [15:0] ea;
    logic [5:0]  ed;
    busy0 = m_busy();
    ready = (q.size() == 0) && !busy0;
    chk("osd_ready", {31'b0, osd_ready}, {31'b0, ready});
    chk("clear_busy", {31'b0, clear_busy}, {31'b0, busy0});
    ew = 1'b0; ea = '0; ed = '0;
    if (q.size() > 0 && !hold) begin
      {ea, ed} = q.pop_front();
      ew = 1'b1;
    end else if (q.size() == 0 && m_active) begin
      ew = 1'b1;
      ea = m_caddr[15:0];
      ed = CC;
      m_caddr++;
      if (m_caddr == 61440) begin
        m_active = 1'b0;
        m_caddr  = 0;
      end
    end else if (osd_valid && ready) begin
      ew = 1'b1; ea = osd_addr; ed = osd_pixel;
    end
    if (ppu_valid && ppu_x < 256 && ppu_y < 240) begin
      if (q.size() < DEPTH) q.push_back({ppu_y[7:0], ppu_x[7:0], ppu_pixel});
      else m_ovf = 1'b1;
    end
`ifdef FB_CLEAR_EN
    if (m_armed && ppu_y >= 240) begin
      m_armed  = 1'b0;
      m_active = 1'b1;
      m_caddr  = 0;
    end else if (!busy0 && clear_req) begin
      m_armed = 1'b1;
    end
`endif
    @(posedge clk);
    #1;
    chk("fb_wren", {31'b0, fb_wren}, {31'b0, ew});
    chk("fb_addr", {16'b0, fb_addr}, {16'b0, ea});
    chk("fb_data", {26'b0, fb_data}, {26'b0, ed});
    chk("ppu_overflow", {31'b0, ppu_overflow}, {31'b0, m_ovf});
    if (fb_wren) begin
      n_writes++;
      if (fb_data == CC) begin
        clr_writes++;
        last_clr_addr = int'(fb_addr);
      end
    end
  endtask

  task automatic idle_inputs();
    ppu_valid = 1'b0; ppu_x = '0; ppu_y = '0; ppu_pixel = '0;
    osd_valid = 1'b0; osd_addr = '0; osd_pixel = '0; clear_req = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_wren"}, {31'b0, fb_wren}, 32'd0);
    chk({tag, "_addr"}, {16'b0, fb_addr}, 32'd0);
    chk({tag, "_data"}, {26'b0, fb_data}, 32'd0);
    chk({tag, "_ovf"}, {31'b0, ppu_overflow}, 32'd0);
    chk({tag, "_busy"}, {31'b0, clear_busy}, 32'd0);
    q.delete();
    hold = 1'b0; m_armed = 1'b0; m_active = 1'b0; m_ovf = 1'b0; m_caddr = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n0;
    idle_inputs();
    n_writes = 0; clr_writes = 0; last_clr_addr = -1;
    do_reset("reset");
    chk("reset_osd_ready", {31'b0, osd_ready}, 32'd1);

    // Single PPU pixel: two-cycle latency, address y*256+x.
    ppu_valid = 1'b1; ppu_x = 9'd5; ppu_y = 9'd3; ppu_pixel = 6'h21;
    step();
    chk("ppu_lat_c1", {31'b0, fb_wren}, 32'd0);
    ppu_valid = 1'b0;
    step();
    chk("ppu_lat_wren", {31'b0, fb_wren}, 32'd1);
    chk("ppu_lat_addr", {16'b0, fb_addr}, 32'h0305);
    chk("ppu_lat_data", {26'b0, fb_data}, 32'h21);

    // Out-of-range coordinates never reach the framebuffer.
    n0 = n_writes;
    ppu_valid = 1'b1; ppu_x = 9'd300; ppu_y = 9'd3;
    step();
    ppu_x = 9'd10; ppu_y = 9'd240;
    step();
    ppu_valid = 1'b0; ppu_y = 9'd0;
    step();
    step();
    chk("range_no_write", n_writes - n0, 32'd0);

    // OSD waits behind a queued PPU pixel.
    ppu_valid = 1'b1; ppu_x = 9'd7; ppu_y = 9'd9; ppu_pixel = 6'h11;
    step();
    ppu_valid = 1'b0;
    osd_valid = 1'b1; osd_addr = 16'h1234; osd_pixel = 6'h30;
    chk("osd_blocked", {31'b0, osd_ready}, 32'd0);
    step();
    chk("osd_ppu_first", {16'b0, fb_addr}, 32'h0907);
    chk("osd_ready_after", {31'b0, osd_ready}, 32'd1);
    step();
    chk("osd_write_addr", {16'b0, fb_addr}, 32'h1234);
    chk("osd_write_data", {26'b0, fb_data}, 32'h30);
    osd_valid = 1'b0;
    step();

    // Overflow with the FIFO drain frozen.
    hold = 1'b1;
    force dut.grant_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ppu_valid = 1'b1; ppu_x = 9'(i * 10); ppu_y = 9'd20; ppu_pixel = 6'(i + 1);
      step();
      if (i == 3) chk("ovf_at_full", {31'b0, ppu_overflow}, 32'd0);
    end
    chk("ovf_set", {31'b0, ppu_overflow}, 32'd1);
    ppu_valid = 1'b0;
    hold = 1'b0;
    release dut.grant_hold;
    n0 = n_writes;
    for (int i = 0; i < 8; i++) step();
    chk("ovf_drain_count", n_writes - n0, 32'd4);
    chk("ovf_sticky", {31'b0, ppu_overflow}, 32'd1);
    do_reset("ovf_reset");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      ppu_valid = 1'($urandom_range(0, 1));
      ppu_x     = 9'($urandom_range(0, 320));
      ppu_y     = 9'($urandom_range(0, 261));
      ppu_pixel = 6'($urandom);
      osd_valid = ($urandom_range(0, 3) == 0);
      osd_addr  = 16'($urandom);
      osd_pixel = 6'($urandom);
`ifndef FB_CLEAR_EN
      clear_req = ($urandom_range(0, 7) == 0);
`endif
      step();
    end
    idle_inputs();
    for (int i = 0; i < 6; i++) step();
    chk("rand_busy_low", {31'b0, clear_busy}, 32'd0);

`ifdef FB_CLEAR_EN
    // Full-screen clear armed mid-frame, run from vblank.
    do_reset("clr_reset");
    ppu_y = 9'd100; clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    chk("clr_armed_busy", {31'b0, clear_busy}, 32'd1);
    n0 = n_writes;
    for (int i = 0; i < 20; i++) begin
      clear_req = (i == 5);
      step();
    end
    clear_req = 1'b0;
    chk("clr_armed_no_write", n_writes - n0, 32'd0);
    ppu_y = 9'd240;
    clr_writes = 0; last_clr_addr = -1;
    for (int c = 0; c < 70000 && m_busy(); c++) begin
      if (c == 500 || c == 30001) begin
        ppu_valid = 1'b1; ppu_y = 9'd10; ppu_x = 9'(c % 256); ppu_pixel = 6'h2A;
      end else begin
        ppu_valid = 1'b0; ppu_y = 9'd240;
      end
      step();
    end
    ppu_valid = 1'b0;
    step();
    step();
    chk("clr_count", clr_writes, 32'd61440);
    chk("clr_last_addr", last_clr_addr, 32'd61439);
    chk("clr_done_busy", {31'b0, clear_busy}, 32'd0);

    // Reset mid-clear aborts it.
    ppu_y = 9'd250; clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int c = 0; c < 5000 && !(m_active && m_caddr == 1000); c++) step();
    chk("abort_busy_before", {31'b0, clear_busy}, 32'd1);
    do_reset("abort");
    n0 = n_writes;
    for (int i = 0; i < 10; i++) step();
    chk("abort_no_write", n_writes - n0, 32'd0);
    chk("abort_busy_after", {31'b0, clear_busy}, 32'd0);
`else
    // Clear requests have no effect in this build.
    n0 = n_writes;
    ppu_y = 9'd250; clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("noclr_no_write", n_writes - n0, 32'd0);
    chk("noclr_busy", {31'b0, clear_busy}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fb_write_sched.md
FB_WRITE_SCHED -- requirements
Module: fb_write_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, PPU pixel FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter CLEAR_COLOR, default 6'h0F, NES palette index written by the clear engine.
REQ-003 SHALL have port clk  input  1  system clock (21 MHz); single clock domain.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ppu_valid  input  1  PPU pixel strobe.
REQ-006 SHALL have port ppu_x  input  9  PPU horizontal count.
REQ-007 SHALL have port ppu_y  input  9  PPU vertical count; sampled every cycle.
REQ-008 SHALL have port ppu_pixel  input  6  palette index.
REQ-009 SHALL have port osd_valid  input  1  OSD write request.
REQ-010 SHALL have port osd_addr  input  16  OSD framebuffer address.
REQ-011 SHALL have port osd_pixel  input  6  OSD palette index.
REQ-012 SHALL have port osd_ready  output  1  OSD write accepted this cycle when high with osd_valid.
REQ-013 SHALL have port clear_req  input  1  single-cycle clear-screen request.
REQ-014 SHALL have port clear_busy  output  1  clear pending or in progress.
REQ-015 SHALL have ports fb_wren  output  1, fb_addr  output  16, fb_data  output  6: framebuffer write port.
REQ-016 SHALL have port ppu_overflow  output  1  sticky PPU pixel-drop flag.

Function
REQ-017 SHALL push a PPU pixel only when ppu_valid && ppu_x<256 && ppu_y<240; address = {ppu_y[7:0], ppu_x[7:0]} (y*256+x).
REQ-018 SHALL drop a qualifying PPU pixel when the FIFO is full and no pop occurs that cycle, and set ppu_overflow; push at full with simultaneous pop SHALL be accepted.
REQ-019 SHALL grant one write source per cycle with fixed priority: FIFO non-empty > clear engine (CLEAR state) > OSD.
REQ-020 SHALL drive osd_ready = FIFO empty && !clear_busy, from registered state only (no dependency on osd_valid).
REQ-021 SHALL register fb_wren/fb_addr/fb_data: granted write appears one cycle after grant; fb_wren low with fb_addr=0, fb_data=0 when no grant.
REQ-022 SHALL give PPU latency of exactly 2 cycles from qualifying ppu_valid to fb_wren when FIFO empty; OSD latency 1 cycle from handshake.
REQ-023 SHALL implement clear FSM states IDLE, ARMED, CLEAR.
REQ-024 SHALL go IDLE->ARMED on clear_req; ARMED->CLEAR on first cycle with ppu_y>=240; CLEAR->IDLE after address 61439 is written.
REQ-025 SHALL in CLEAR write CLEAR_COLOR at a 16-bit counter starting at 0, incrementing only on granted cycles (stalls while FIFO non-empty).
REQ-026 SHALL ignore clear_req in ARMED or CLEAR; clear_busy high in ARMED and CLEAR.
REQ-027 SHALL never write an address above 61439 from PPU or clear paths; OSD addresses pass unchecked.

Reset
REQ-028 SHALL on rst_n low asynchronously: empty FIFO, FSM to IDLE, clear counter 0, fb_wren=0, fb_addr=0, fb_data=0, ppu_overflow=0, clear_busy=0.
REQ-029 SHALL abort an in-progress clear on reset mid-operation; no write issues in the reset-release cycle.
REQ-030 SHALL clear ppu_overflow only by reset.

Configuration
REQ-031 SHALL compile the clear engine only when macro FB_CLEAR_EN is defined.
REQ-032 SHALL without FB_CLEAR_EN: ignore clear_req, tie clear_busy to 0, omit FSM/counter, osd_ready = FIFO empty; ports unchanged.

Verification
REQ-033 SHALL cover: ppu_valid, x=5, y=3, pixel=0x21, idle -> cycle+2 fb_wren=1, fb_addr=0x0305, fb_data=0x21.
REQ-034 SHALL cover: ppu_valid with x=300 or y=240 -> no FIFO push, fb_wren stays 0.
REQ-035 SHALL cover: osd_valid with addr=0x1234, pixel=0x30 while a PPU pixel is pushed -> PPU written first, osd_ready low until FIFO empty, then OSD write at 0x1234.
REQ-036 SHALL cover: FIFO_DEPTH=4, 5 qualifying PPU pushes with grants forced away (FIFO full, no pop) -> 5th dropped, ppu_overflow=1 until reset.
REQ-037 SHALL cover (FB_CLEAR_EN): clear_req at ppu_y=100 -> ARMED until ppu_y=240, then 61440 writes of 0x0F, addresses 0..61439, clear_busy falls after last.
REQ-038 SHALL cover: rst_n low at clear counter=1000 -> all outputs 0 at once; after release clear_busy=0, no writes until new request.
